// File: rtl/irq_vector_responder.sv
// 68000 interrupt responder: drives IPL for masked level requests and answers the
// matching IACK cycle with a per-source vector byte, or the spurious vector when nothing is pending.
module irq_vector_responder #(
   parameter int unsigned NSRC        = 4,
   parameter logic [2:0]  LEVEL       = 3'd4,
   parameter logic [7:0]  VECTOR_BASE = 8'h40,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic            i_CLK,
   input  logic            i_RESET_n,
   input  logic [NSRC-1:0] i_IRQ,
   input  logic [NSRC-1:0] i_MASK,
   input  logic            i_AS_n,
   input  logic [2:0]      i_FC,
   input  logic [2:0]      i_A_LOW,
   output logic [2:0]      o_IPL_n,
   output logic            o_DTACK_n,
   output logic [7:0]      o_D,
   output logic            o_D_OE,
   output logic [NSRC-1:0] o_ACK_SRC
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_WAIT,
      ST_ACK,
      ST_RELEASE
   } state_t;

   state_t          state;
   logic            s1, s2, s3;
   logic            as_fall, as_high;
   logic [3:0]      cnt;
   logic [NSRC-1:0] pending, first_hot, hot_q, sel_hot;
   logic [2:0]      first_idx, idx_q, sel_idx;
   logic            hit_q, sel_hit, found, go_ack;
   logic [7:0]      vector;

   assign pending   = i_IRQ & i_MASK;
   assign first_hot = pending & (~pending + NSRC'(1));
   assign as_fall   = !s2 && s3;
   assign as_high   = s2;

   always_comb begin
      first_idx = '0;
      found     = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (pending[i] && !found) begin
            first_idx = 3'(i);
            found     = 1'b1;
         end
      end
   end

   // With no wait states the ACK is entered from LATCH, so use the live arbitration result there.
   always_comb begin
      sel_hit = hit_q;
      sel_idx = idx_q;
      sel_hot = hot_q;
      if (state == ST_LATCH) begin
         sel_hit = found;
         sel_idx = first_idx;
         sel_hot = first_hot;
      end
      vector = sel_hit ? (VECTOR_BASE + {5'b0, sel_idx}) : 8'h18;
      go_ack = !as_high &&
               (((state == ST_LATCH) && (WAIT_STATES == 0)) ||
                ((state == ST_WAIT) && (cnt == 4'd1)));
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RESET_n) begin
         state     <= ST_IDLE;
         s1        <= 1'b1;
         s2        <= 1'b1;
         s3        <= 1'b1;
         cnt       <= '0;
         idx_q     <= '0;
         hit_q     <= 1'b0;
         hot_q     <= '0;
         o_IPL_n   <= 3'b111;
         o_DTACK_n <= 1'b1;
         o_D       <= 8'h00;
         o_D_OE    <= 1'b0;
         o_ACK_SRC <= '0;
      end else begin
         s1        <= i_AS_n;
         s2        <= s1;
         s3        <= s2;
         o_IPL_n   <= (pending != '0) ? ~LEVEL : 3'b111;
         o_ACK_SRC <= '0;

         case (state)
            ST_IDLE: begin
               if (as_fall && (i_FC == 3'b111) && (i_A_LOW == LEVEL))
                  state <= ST_LATCH;
            end
            ST_LATCH: begin
               if (as_high) begin
                  state <= ST_RELEASE;
               end else begin
                  idx_q <= first_idx;
                  hit_q <= found;
                  hot_q <= first_hot;
                  cnt   <= 4'(WAIT_STATES);
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (as_high)
                  state <= ST_RELEASE;
               else
                  cnt <= cnt - 4'd1;
            end
            ST_ACK: begin
               if (as_high) begin
                  state     <= ST_RELEASE;
                  o_DTACK_n <= 1'b1;
                  o_D_OE    <= 1'b0;
                  o_D       <= 8'h00;
               end
            end
            ST_RELEASE: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase

         // Overrides the state update above on the edge where the wait period ends.
         if (go_ack) begin
            state     <= ST_ACK;
            o_DTACK_n <= 1'b0;
            o_D_OE    <= 1'b1;
            o_D       <= vector;
            o_ACK_SRC <= sel_hit ? sel_hot : '0;
         end
      end
   end

endmodule
